mem_bridge: RTL and testbench
=============================

# mem_bridge

Parametrised synchronous bus bridge between the CPU control/datapath memory interface and an external memory device. It replaces the current direct combinational hookup of the memory address buses to test memory. It adds programmable wait states, external ready stretching, a timeout with an error flag, and registered read data. The CPU issues one request at a time and holds it until acknowledged.

## Interface
Parameters:
- ADDR_W, 16, address width (CPU high and low buses concatenated).
- DATA_W, 8, data width.
- WAIT_STATES, 0, fixed extra strobe cycles per access (0..15).
- TIMEOUT, 64, maximum cycles waiting on ext_ready after the fixed waits (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cpu_req  in  1  request; held high until cpu_ack.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_addr  in  ADDR_W  access address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  registered read data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  one-cycle pulse with cpu_ack on timeout.
- busy  out  1  high in any state other than IDLE.
- ext_addr  out  ADDR_W  registered address.
- ext_rw  out  1  1 = read, 0 = write.
- ext_we  out  1  write strobe.
- ext_oe  out  1  bridge drives ext_wdata onto the external data bus.
- ext_wdata  out  DATA_W  registered write data.
- ext_rdata  in  DATA_W  external read data.
- ext_ready  in  1  external device ready; tie high if unused.

## Operation
- States: IDLE, SETUP, STROBE, WAIT, DONE.
- **IDLE**
  - If cpu_req=1: latch cpu_addr→ext_addr, cpu_rw→ext_rw, cpu_wdata→ext_wdata, load the wait counter with WAIT_STATES, then go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP**: one cycle for address setup.
  - ext_oe = ~ext_rw; ext_we = 0.
  - Always go to STROBE.
- **STROBE**: one cycle.
  - ext_we = ~ext_rw; ext_oe = ~ext_rw.
  - If the wait counter is not 0, go to WAIT.
  - Else if ext_ready=1, go to DONE.
  - Else go to WAIT with the timeout counter cleared.
- **WAIT**: ext_we and ext_oe as in STROBE.
  - Decrement the wait counter while it is nonzero.
  - Once it is 0, count cycles with ext_ready=0.
  - ext_ready=1 with the wait counter at 0: go to DONE.
  - Timeout count reaches TIMEOUT: go to DONE with the error flagged.
- **DONE**: one cycle.
  - cpu_ack=1; cpu_err=1 if timed out.
  - ext_we = 0, ext_oe = 0.
  - Always go to IDLE; cpu_req is ignored in DONE.
- **Read capture**: on reads, cpu_rdata is loaded from ext_rdata at the clock edge leaving STROBE/WAIT for DONE, only on a non-error completion. On timeout, cpu_rdata keeps its previous value.
- **Writes**: cpu_rdata is unchanged.
- **Address/data stability**: ext_addr, ext_rw and ext_wdata stay constant from SETUP through DONE. They change only on acceptance in IDLE.
- **ext_rw in IDLE**: holds the last access's value. Reset value is 1 (read).
- **Counter widths**: wait counter is clog2(WAIT_STATES+1) bits, minimum 1. Timeout counter is clog2(TIMEOUT+1) bits. Neither counter wraps.

## Timing
- **Reset** (rst_n low at a rising edge), effective that edge, including mid-access:
  - state → IDLE.
  - ext_addr=0, ext_wdata=0, ext_rw=1, cpu_rdata=0.
  - cpu_ack=0, cpu_err=0, ext_we=0, ext_oe=0, busy=0.
  - Counters → 0.
  - No ack is ever issued for an aborted access.
- **Latency**, where cycle 0 is the IDLE cycle that samples cpu_req=1:
  - SETUP is cycle 1, STROBE is cycle 2.
  - With ext_ready=1, cpu_ack is high in cycle 3+WAIT_STATES.
  - Each cycle with ext_ready=0 after the fixed waits adds one cycle.
  - A timeout acks in cycle 3+WAIT_STATES+TIMEOUT.
- **Back-to-back**: a request held or re-raised during DONE is accepted in the following IDLE cycle. Minimum request spacing is 4+WAIT_STATES cycles.
- **ext_we width**: 1+WAIT_STATES+(ready stall) cycles. It is never asserted in SETUP or DONE.
- **ext_ready sampling**: ignored in IDLE, SETUP and DONE, and ignored while the wait counter is nonzero.
- **Output registering**: cpu_ack, cpu_err, busy, ext_we and ext_oe are decoded from registered state only. No combinational path exists from any input to any output.

## Test plan
- **Read**, WAIT_STATES=2, ext_ready=1, cpu_addr=16'h1234, ext_rdata=8'hA5: cpu_ack high at cycle 5, cpu_rdata=8'hA5, ext_we never high, cpu_err=0.
- **Write**, WAIT_STATES=0, cpu_addr=16'hFFFC, cpu_wdata=8'h3C: ext_we high for cycle 2 only, ext_oe high in cycles 1–2, ext_wdata=8'h3C, cpu_ack at cycle 3.
- **Ready stretch**, WAIT_STATES=1, ext_ready low for 3 cycles after the fixed wait: cpu_ack at cycle 7, ext_addr stable throughout, cpu_err=0.
- **Timeout**, TIMEOUT=4, ext_ready stuck low, WAIT_STATES=0: cpu_ack and cpu_err both high at cycle 7, cpu_rdata unchanged from its prior value 8'h5A.
- **Reset in WAIT** during a write: the next edge gives ext_we=0, ext_rw=1, busy=0, and no cpu_ack follows. A new read is then accepted normally.
- **Back-to-back**: read then write with cpu_req held high, WAIT_STATES=0: acks at cycles 3 and 7, second access uses the new address and rw.

Source files
------------

// File: rtl/mem_bridge.sv
// Synchronous bridge from the CPU memory port to an external memory device.
// Registered address/data, programmable wait states, ready stretching and a timeout.
module mem_bridge #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              busy,
    output logic [ADDR_W-1:0] ext_addr,
    output logic              ext_rw,
    output logic              ext_we,
    output logic              ext_oe,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic [DATA_W-1:0] ext_rdata,
    input  logic              ext_ready
);
    localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [WCNT_W-1:0] WAIT_LOAD  = WCNT_W'(WAIT_STATES);
    localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
    localparam logic [TCNT_W-1:0] TOUT_LIMIT = TCNT_W'(TIMEOUT);
    localparam logic [TCNT_W-1:0] TCNT_ONE   = TCNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] wait_cnt;
    logic [TCNT_W-1:0] tout_cnt;
    logic              finish_ok;
    logic              finish_err;

    // Ready is only sampled once the fixed waits are used up; tout_cnt holds the low samples seen so far.
    always_comb begin
        finish_ok  = 1'b0;
        finish_err = 1'b0;
        if ((state == S_STROBE || state == S_WAIT) && wait_cnt == '0) begin
            if (ext_ready)
                finish_ok = 1'b1;
            else if (state == S_WAIT && tout_cnt == TOUT_LIMIT)
                finish_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            tout_cnt  <= '0;
            ext_addr  <= '0;
            ext_wdata <= '0;
            ext_rw    <= 1'b1;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            busy      <= 1'b0;
            ext_we    <= 1'b0;
            ext_oe    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            if (finish_ok || finish_err) begin
                state   <= S_DONE;
                cpu_ack <= 1'b1;
                cpu_err <= finish_err;
                ext_we  <= 1'b0;
                ext_oe  <= 1'b0;
                if (finish_ok && ext_rw)
                    cpu_rdata <= ext_rdata;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cpu_req) begin
                            ext_addr  <= cpu_addr;
                            ext_rw    <= cpu_rw;
                            ext_wdata <= cpu_wdata;
                            wait_cnt  <= WAIT_LOAD;
                            tout_cnt  <= '0;
                            state     <= S_SETUP;
                            busy      <= 1'b1;
                            ext_oe    <= ~cpu_rw;
                            ext_we    <= 1'b0;
                        end
                    end
                    S_SETUP: begin
                        state  <= S_STROBE;
                        ext_we <= ~ext_rw;
                        ext_oe <= ~ext_rw;
                    end
                    S_STROBE, S_WAIT: begin
                        state <= S_WAIT;
                        if (wait_cnt != '0)
                            wait_cnt <= wait_cnt - WCNT_ONE;
                        else
                            tout_cnt <= tout_cnt + TCNT_ONE;
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        ext_we <= 1'b0;
                        ext_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Bench for mem_bridge: three instances (WAIT_STATES 0,1,2; TIMEOUT 4) run directed cases and
// random traffic, compared every cycle against a cycle-count transaction model.
module tb_mem_bridge;
    localparam int N_DUT = 3;
    localparam int TOUT  = 4;

    logic clk = 1'b0;
    logic rst_n;

    logic        req    [N_DUT];
    logic        rw     [N_DUT];
    logic [15:0] addr   [N_DUT];
    logic [7:0]  wdata  [N_DUT];
    logic [7:0]  rd_ext [N_DUT];
    logic        rdy    [N_DUT];

    logic [7:0]  rdata   [N_DUT];
    logic        ack     [N_DUT];
    logic        err     [N_DUT];
    logic        busy    [N_DUT];
    logic [15:0] e_addr  [N_DUT];
    logic        e_rw    [N_DUT];
    logic        we      [N_DUT];
    logic        oe      [N_DUT];
    logic [7:0]  e_wdata [N_DUT];

    // Model state: in an access, in its DONE cycle, and the cycle index since acceptance
    bit          m_act   [N_DUT];
    bit          m_fin   [N_DUT];
    int          m_k     [N_DUT];
    logic [7:0]  x_rdata [N_DUT];
    logic        x_ack   [N_DUT];
    logic        x_err   [N_DUT];
    logic        x_busy  [N_DUT];
    logic [15:0] x_addr  [N_DUT];
    logic        x_rw    [N_DUT];
    logic        x_we    [N_DUT];
    logic        x_oe    [N_DUT];
    logic [7:0]  x_wdata [N_DUT];

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        mem_bridge #(
            .ADDR_W(16), .DATA_W(8), .WAIT_STATES(g), .TIMEOUT(TOUT)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .cpu_req(req[g]), .cpu_rw(rw[g]), .cpu_addr(addr[g]), .cpu_wdata(wdata[g]),
            .cpu_rdata(rdata[g]), .cpu_ack(ack[g]), .cpu_err(err[g]), .busy(busy[g]),
            .ext_addr(e_addr[g]), .ext_rw(e_rw[g]), .ext_we(we[g]), .ext_oe(oe[g]),
            .ext_wdata(e_wdata[g]), .ext_rdata(rd_ext[g]), .ext_ready(rdy[g])
        );
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s dut%0d: got %0h, expected %0h at %0t", name, inst, actual, expected, $time);
        end
    endtask

    // Ready is first looked at in cycle 2+W; the access ends the cycle after a high sample,
    // or after TOUT further low samples with the error flag.
    always @(posedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            x_ack[i] = 1'b0;
            x_err[i] = 1'b0;
            if (!rst_n) begin
                m_act[i]   = 1'b0;
                m_fin[i]   = 1'b0;
                m_k[i]     = 0;
                x_addr[i]  = '0;
                x_wdata[i] = '0;
                x_rw[i]    = 1'b1;
                x_rdata[i] = '0;
            end else if (!m_act[i]) begin
                if (req[i]) begin
                    m_act[i]   = 1'b1;
                    m_k[i]     = 1;
                    x_addr[i]  = addr[i];
                    x_rw[i]    = rw[i];
                    x_wdata[i] = wdata[i];
                end
            end else if (m_fin[i]) begin
                m_act[i] = 1'b0;
                m_fin[i] = 1'b0;
            end else begin
                if (m_k[i] >= 2 + i && (rdy[i] || m_k[i] == 2 + i + TOUT)) begin
                    m_fin[i] = 1'b1;
                    x_ack[i] = 1'b1;
                    x_err[i] = !rdy[i];
                    if (rdy[i] && x_rw[i])
                        x_rdata[i] = rd_ext[i];
                end
                m_k[i]++;
            end
            x_busy[i] = m_act[i];
            x_oe[i]   = m_act[i] && !m_fin[i] && !x_rw[i];
            x_we[i]   = m_act[i] && !m_fin[i] && (m_k[i] >= 2) && !x_rw[i];
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < N_DUT; i++) begin
                checkOutput("cpu_ack", i, ack[i], x_ack[i]);
                checkOutput("cpu_err", i, err[i], x_err[i]);
                checkOutput("busy", i, busy[i], x_busy[i]);
                checkOutput("ext_we", i, we[i], x_we[i]);
                checkOutput("ext_oe", i, oe[i], x_oe[i]);
                checkOutput("ext_rw", i, e_rw[i], x_rw[i]);
                checkOutput("ext_addr", i, e_addr[i], x_addr[i]);
                checkOutput("ext_wdata", i, e_wdata[i], x_wdata[i]);
                checkOutput("cpu_rdata", i, rdata[i], x_rdata[i]);
            end
        end
    end

    // One access from an IDLE negedge; ready is low for low_n samples starting at cycle 2+W.
    task automatic applyStimulus(input int i, input logic r, input logic [15:0] a,
                                 input logic [7:0] wd, input logic [7:0] rd, input int low_n,
                                 output int ack_c, output bit err_s, output int we_f, output int we_n,
                                 output int oe_f, output int oe_n, output bit stable);
        int s0;
        s0 = 2 + i;
        req[i] = 1'b1; rw[i] = r; addr[i] = a; wdata[i] = wd; rd_ext[i] = rd; rdy[i] = 1'b1;
        ack_c = -1; err_s = 1'b0; we_f = -1; we_n = 0; oe_f = -1; oe_n = 0; stable = 1'b1;
        for (int c = 1; c <= 100 && ack_c < 0; c++) begin
            @(negedge clk);
            if (we[i]) begin
                if (we_f < 0) we_f = c;
                we_n++;
            end
            if (oe[i]) begin
                if (oe_f < 0) oe_f = c;
                oe_n++;
            end
            if (e_addr[i] != a) stable = 1'b0;
            if (ack[i]) begin
                ack_c = c;
                err_s = err[i];
                req[i] = 1'b0;
            end
            rdy[i] = !(c >= s0 && c < s0 + low_n);
        end
        req[i] = 1'b0;
        rdy[i] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int  ack_c, we_f, we_n, oe_f, oe_n, first, second;
        bit  err_s, stable, seen, done, stuck;

        for (int i = 0; i < N_DUT; i++) begin
            req[i] = 1'b0; rw[i] = 1'b1; addr[i] = '0; wdata[i] = '0; rd_ext[i] = '0; rdy[i] = 1'b1;
            m_act[i] = 1'b0; m_fin[i] = 1'b0; m_k[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            checkOutput("rst_busy", i, busy[i], 0);
            checkOutput("rst_ext_rw", i, e_rw[i], 1);
            checkOutput("rst_ack", i, ack[i], 0);
            checkOutput("rst_rdata", i, rdata[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed: read with two wait states");
        applyStimulus(2, 1'b1, 16'h1234, 8'h00, 8'hA5, 0, ack_c, err_s, we_f, we_n, oe_f, oe_n, stable);
        checkOutput("rd_ack_cycle", 2, ack_c, 5);
        checkOutput("rd_rdata", 2, rdata[2], 8'hA5);
        checkOutput("rd_we_count", 2, we_n, 0);
        checkOutput("rd_err", 2, err_s, 0);

        $display("[TB] directed: write with no wait states");
        applyStimulus(0, 1'b0, 16'hFFFC, 8'h3C, 8'h00, 0, ack_c, err_s, we_f, we_n, oe_f, oe_n, stable);
        checkOutput("wr_ack_cycle", 0, ack_c, 3);
        checkOutput("wr_we_first", 0, we_f, 2);
        checkOutput("wr_we_count", 0, we_n, 1);
        checkOutput("wr_oe_first", 0, oe_f, 1);
        checkOutput("wr_oe_count", 0, oe_n, 2);
        checkOutput("wr_wdata", 0, e_wdata[0], 8'h3C);

        $display("[TB] directed: ready stretch");
        applyStimulus(1, 1'b1, 16'hBEEF, 8'h00, 8'h42, 3, ack_c, err_s, we_f, we_n, oe_f, oe_n, stable);
        checkOutput("str_ack_cycle", 1, ack_c, 7);
        checkOutput("str_addr_stable", 1, stable, 1);
        checkOutput("str_err", 1, err_s, 0);

        $display("[TB] directed: timeout");
        applyStimulus(0, 1'b1, 16'h0040, 8'h00, 8'h5A, 0, ack_c, err_s, we_f, we_n, oe_f, oe_n, stable);
        checkOutput("pre_to_rdata", 0, rdata[0], 8'h5A);
        applyStimulus(0, 1'b1, 16'h0041, 8'h00, 8'hC3, 1000, ack_c, err_s, we_f, we_n, oe_f, oe_n, stable);
        checkOutput("to_ack_cycle", 0, ack_c, 7);
        checkOutput("to_err", 0, err_s, 1);
        checkOutput("to_rdata_kept", 0, rdata[0], 8'h5A);

        $display("[TB] directed: reset during a write wait");
        req[2] = 1'b1; rw[2] = 1'b0; addr[2] = 16'h0BAD; wdata[2] = 8'h11; rdy[2] = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_pre_we", 2, we[2], 1);
        rst_n = 1'b0;
        req[2] = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_we", 2, we[2], 0);
        checkOutput("rst_mid_rw", 2, e_rw[2], 1);
        checkOutput("rst_mid_busy", 2, busy[2], 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (ack[2]) seen = 1'b1;
        end
        checkOutput("rst_no_ack", 2, seen, 0);
        applyStimulus(2, 1'b1, 16'h2222, 8'h00, 8'h6E, 0, ack_c, err_s, we_f, we_n, oe_f, oe_n, stable);
        checkOutput("post_rst_ack_cycle", 2, ack_c, 5);
        checkOutput("post_rst_rdata", 2, rdata[2], 8'h6E);

        $display("[TB] directed: back-to-back read then write");
        req[0] = 1'b1; rw[0] = 1'b1; addr[0] = 16'h0100; wdata[0] = 8'h00; rd_ext[0] = 8'h77; rdy[0] = 1'b1;
        first = -1; second = -1;
        for (int c = 1; c <= 40 && second < 0; c++) begin
            @(negedge clk);
            if (ack[0]) begin
                if (first < 0) begin
                    first = c;
                    checkOutput("b2b_rdata", 0, rdata[0], 8'h77);
                    rw[0] = 1'b0; addr[0] = 16'h0200; wdata[0] = 8'h99;
                end else begin
                    second = c;
                    checkOutput("b2b_addr2", 0, e_addr[0], 16'h0200);
                    checkOutput("b2b_rw2", 0, e_rw[0], 0);
                    checkOutput("b2b_wdata2", 0, e_wdata[0], 8'h99);
                    req[0] = 1'b0;
                end
            end
        end
        req[0] = 1'b0;
        checkOutput("b2b_ack1_cycle", 0, first, 3);
        checkOutput("b2b_ack2_cycle", 0, second, 7);
        @(negedge clk);

        $display("[TB] random traffic");
        for (int i = 0; i < N_DUT; i++) begin
            for (int n = 0; n < 60; n++) begin
                stuck = ($urandom_range(0, 9) == 0);
                req[i] = 1'b1;
                rw[i] = 1'($urandom);
                addr[i] = 16'($urandom);
                wdata[i] = 8'($urandom);
                done = 1'b0;
                for (int c = 0; c < 60 && !done; c++) begin
                    rd_ext[i] = 8'($urandom);
                    rdy[i] = stuck ? 1'b0 : ($urandom_range(0, 9) < 6);
                    @(negedge clk);
                    done = ack[i];
                end
                checkOutput("rand_ack_wait", i, done, 1);
                if ($urandom_range(0, 1) == 1) begin
                    req[i] = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
            end
            req[i] = 1'b0;
            rdy[i] = 1'b1;
            repeat (3) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
